// File: rtl/exhaustive_vector_checker_pkg.sv
// exhaustive_vector_checker_pkg: shared state encoding and default hold time for the sweep harness
package exhaustive_vector_checker_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;
    localparam int HOLD_DEFAULT = 10;
endpackage

// File: rtl/exhaustive_vector_checker_vec_hold_timer.sv
// vec_hold_timer: counts the cycles a vector has been driven and flags the last one
module vec_hold_timer #(
    parameter int HOLD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last
);
    localparam int W = $clog2(HOLD + 1);
    logic [W-1:0] hold_cnt;
    assign last = hold_cnt == W'(HOLD - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_cnt <= '0;
        else if (clear || (en && last))
            hold_cnt <= '0;
        else if (en)
            hold_cnt <= hold_cnt + 1'b1;
    end
endmodule

// File: rtl/exhaustive_vector_checker.sv
// exhaustive_vector_checker: sweeps every input vector of a combinational DUT and
// compares each response against a parametrised truth table.
module exhaustive_vector_checker
    import exhaustive_vector_checker_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter int HOLD  = HOLD_DEFAULT,
    parameter logic [N_OUT*(1<<N_IN)-1:0] EXPECT = 16'h6996
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop_on_err,
    output logic [N_IN-1:0]  vec_out,
    output logic             vec_valid,
    input  logic [N_OUT-1:0] dut_resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_err_vec,
    output logic             first_err_valid
);
    state_t state, state_n;
    logic stop_mode, last, start_ok, sample, mismatch, finish;
    assign start_ok  = start && state != S_DRIVE;
    assign sample    = state == S_DRIVE && last;
    assign mismatch  = dut_resp != EXPECT[int'(vec_out)*N_OUT +: N_OUT];
    assign finish    = sample && (&vec_out || (stop_mode && mismatch));
    assign vec_valid = state == S_DRIVE;
    assign busy      = vec_valid;
    assign pass      = done && err_count == '0;

    vec_hold_timer #(.HOLD(HOLD)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(start_ok),
        .en   (vec_valid),
        .last (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (start_ok)
            state_n = S_DRIVE;
        else if (finish)
            state_n = S_DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_out         <= '0;
            stop_mode       <= 1'b0;
            done            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else if (start_ok) begin
            vec_out         <= '0;
            stop_mode       <= stop_on_err;
            done            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else if (sample) begin
            // vec_out freezes on the final/failing vector so it stays readable in DONE
            if (finish)
                done <= 1'b1;
            else
                vec_out <= vec_out + 1'b1;
            if (mismatch) begin
                err_count <= err_count + 1'b1;
                if (!first_err_valid) begin
                    first_err_vec   <= vec_out;
                    first_err_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// tb_exhaustive_vector_checker: scoreboard bench with a truth-table reference model
module tb_exhaustive_vector_checker;
    typedef struct {
        int err;
        int fev;
        int fevld;
        int pass;
        int last_vec;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, stop_on_err = 1'b0;
    logic [3:0] vec_out, first_err_vec;
    logic [4:0] err_count;
    logic vec_valid, busy, done, pass, first_err_valid;
    logic [15:0] err_mask = '0;
    logic dut_resp;

    logic start2 = 1'b0;
    logic [1:0] vec_out2, first_err_vec2, dut_resp2;
    logic [1:0] flip2 = '0;
    logic [2:0] err_count2;
    logic vec_valid2, busy2, done2, pass2, first_err_valid2;

    int checks = 0, failures = 0;
    int exp_vec_q[$];
    res_t exp_res_q[$];
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    // stand-in DUT: 4-input parity with selectable wrong vectors
    assign dut_resp  = ^vec_out ^ err_mask[vec_out];
    assign dut_resp2 = vec_out2 ^ (vec_out2 == 2'd2 ? flip2 : 2'd0);

    exhaustive_vector_checker dut (
        .clk(clk), .rst(rst), .start(start), .stop_on_err(stop_on_err),
        .vec_out(vec_out), .vec_valid(vec_valid), .dut_resp(dut_resp),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
    );

    exhaustive_vector_checker #(.N_IN(2), .N_OUT(2), .HOLD(1), .EXPECT(8'b11_10_01_00)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .stop_on_err(1'b0),
        .vec_out(vec_out2), .vec_valid(vec_valid2), .dut_resp(dut_resp2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .first_err_vec(first_err_vec2), .first_err_valid(first_err_valid2)
    );

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic push_model(input logic [15:0] mask, input bit stop);
        res_t r;
        logic [15:0] tbl;
        bit resp;
        tbl = 16'h6996;
        r = '{0, 0, 0, 0, 0};
        for (int v = 0; v < 16; v++) begin
            resp = ($countones(v) % 2 == 1) ^ mask[v];
            for (int h = 0; h < 10; h++) exp_vec_q.push_back(v);
            r.last_vec = v;
            if (resp != tbl[v]) begin
                if (r.err == 0) begin
                    r.fev = v;
                    r.fevld = 1;
                end
                r.err++;
                if (stop) break;
            end
        end
        r.pass = (r.err == 0) ? 1 : 0;
        exp_res_q.push_back(r);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_vec_q.delete();
            exp_res_q.delete();
            prev_done = 1'b0;
        end else begin
            if (vec_valid) begin
                chk("busy_eq_valid", busy, 1);
                if (exp_vec_q.size() == 0)
                    chk("unexpected_vec_valid", 1, 0);
                else
                    chk("vec_out", vec_out, exp_vec_q.pop_front());
            end
            if (done && !prev_done) begin
                chk("vec_valid_count", exp_vec_q.size(), 0);
                chk("valid_low_in_done", vec_valid, 0);
                if (exp_res_q.size() == 0)
                    chk("unexpected_done", 1, 0);
                else begin
                    res_t r;
                    r = exp_res_q.pop_front();
                    chk("err_count", err_count, r.err);
                    chk("first_err_vec", first_err_vec, r.fev);
                    chk("first_err_valid", first_err_valid, r.fevld);
                    chk("pass", pass, r.pass);
                    chk("final_vec_out", vec_out, r.last_vec);
                end
            end
            prev_done = done;
        end
    end

    task automatic launch(input logic [15:0] mask, input bit stop);
        err_mask = mask;
        push_model(mask, stop);
        start = 1'b1;
        stop_on_err = stop;
        @(posedge clk); #1;
        start = 1'b0;
        stop_on_err = 1'($urandom);
        chk("start_done_clr", done, 0);
        chk("start_err_clr", err_count, 0);
        chk("start_fev_clr", first_err_valid, 0);
        chk("start_valid", vec_valid, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", done, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_sticky", done, 1);
    endtask

    task automatic run_small(input logic [1:0] flip, input int exp_err);
        int cnt = 0;
        int n = 0;
        flip2 = flip;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        while (!done2 && n < 20) begin
            if (vec_valid2) begin
                chk("small_vec_out", vec_out2, cnt);
                cnt++;
            end
            @(posedge clk); #1;
            n++;
        end
        chk("small_done", done2, 1);
        chk("small_valid_cycles", cnt, 4);
        chk("small_done_cycle", n, 4);
        chk("small_err_count", err_count2, exp_err);
        chk("small_pass", pass2, exp_err == 0 ? 1 : 0);
        chk("small_fev", first_err_vec2, exp_err == 0 ? 0 : 2);
    endtask

    initial begin
        int n;
        #1;
        chk("reset_vec_out", vec_out, 0);
        chk("reset_valid", vec_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_pass", pass, 0);
        chk("reset_err", err_count, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        launch(16'h0000, 1'b0);
        wait_done();
        launch(16'h6996, 1'b0);
        wait_done();
        launch(16'h0020, 1'b1);
        wait_done();
        chk("stop_vec_hold", vec_out, 5);
        launch(16'h6996, 1'b0);
        wait_done();

        launch(16'h0000, 1'b0);
        n = 0;
        while (vec_out != 4'd3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_vec3", vec_out, 3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (vec_out != 4'd7 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_vec7", vec_out, 7);
        rst = 1'b1;
        #1;
        chk("rst_vec_out", vec_out, 0);
        chk("rst_valid", vec_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fev", {first_err_vec, first_err_valid, pass}, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        launch(16'h0000, 1'b0);
        wait_done();

        for (int i = 0; i < 4; i++) begin
            launch(16'($urandom), 1'($urandom));
            wait_done();
        end

        run_small(2'b00, 0);
        @(posedge clk); #1;
        run_small(2'b01, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
